// File: rtl/dff_ram_param.sv
// Parametrised single-port flip-flop RAM with lane write mask, optional output
// register, read-valid strobe and a post-reset clear sequencer.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active high
//   en       : access enable, active low
//   wr       : 0 = write, 1 = read (sampled when en = 0)
//   address  : word address
//   wmask    : per-lane write enable, lane i = bits i*LANE_W +: LANE_W
//   data_in  : write data
//   data_out : read data, held until the next read completes
//   rd_valid : one-cycle pulse when data_out takes new read data
//   busy     : high while the clear sequencer runs; accesses ignored
module dff_ram_param #(
    parameter  int DATA_W       = 72,
    parameter  int DEPTH        = 4,
    parameter  int LANE_W       = 8,
    parameter  int OUT_REG      = 0,
    parameter  int CLEAR_ON_RST = 1,
    localparam int NLANES       = DATA_W / LANE_W,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [NLANES-1:0] wmask,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $error("dff_ram_param: DATA_W must be a multiple of LANE_W");
    end

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              rd_issue;
    logic              wr_go;
    logic [DATA_W-1:0] rdata;

    // Only a non power-of-two depth leaves unused address codes.
    if ((1 << ADDR_W) == DEPTH) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
    end

    assign rd_issue = (state == READY) && !en && wr;
    assign wr_go    = (state == READY) && !en && !wr && in_range;
    assign rdata    = in_range ? mem[address] : '0;

    // Clear sequencer: one zeroed word per cycle, then idle in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            if (CLEAR_ON_RST != 0) begin
                state <= CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= READY;
                busy  <= 1'b0;
            end
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) begin
                state <= READY;
                busy  <= 1'b0;
                ptr   <= '0;
            end
        end
    end

    // Storage is never reset directly; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_go) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (wmask[i]) begin
                        mem[address][i*LANE_W +: LANE_W] <=
                            data_in[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              s1_valid;
        logic [DATA_W-1:0] s1_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
                rd_valid <= 1'b0;
                data_out <= '0;
            end else begin
                s1_valid <= rd_issue;
                if (rd_issue) begin
                    s1_data <= rdata;
                end
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= s1_data;
                end
            end
        end
    end else begin : g_nreg
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid <= 1'b0;
                data_out <= '0;
            end else begin
                rd_valid <= rd_issue;
                if (rd_issue) begin
                    data_out <= rdata;
                end
            end
        end
    end

endmodule
